// File: rtl/dmem_xlate.sv
// Data-side access controller: drives the TLB, classifies the translation into MIPS
// exceptions, issues the physical access to the data cache and returns aligned/extended loads.
module dmem_xlate (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_wdata,
  input  logic        kernel,
  input  logic        flush,
  output logic [31:0] tlb_vaddr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_hit,
  input  logic        tlb_cached,
  input  logic        tlb_dirty,
  input  logic        tlb_valid,
  input  logic        tlb_user,
  output logic        dc_req,
  output logic        dc_wr,
  output logic [31:0] dc_paddr,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  output logic        dc_cached,
  input  logic        dc_gnt,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        exc_refill,
  output logic [31:0] exc_badvaddr
);

  typedef enum logic [2:0] {IDLE, XLATE, ISSUE, WAIT_R, DRAIN} state_t;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  state_t      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        misal_q, misal_d;
  logic [31:0] paddr_q, paddr_d;
  logic        cached_q, cached_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] lane_q, lane_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        exc_valid_q, exc_valid_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic        exc_refill_q, exc_refill_d;
  logic [31:0] exc_badvaddr_q, exc_badvaddr_d;

  logic        xc_any;
  logic        xc_refill;
  logic [4:0]  xc_code;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;

  // Translation fault classification, highest priority first.
  always_comb begin
    xc_any    = 1'b1;
    xc_refill = 1'b0;
    xc_code   = 5'd0;
    if (misal_q || (!kernel && !tlb_user)) begin
      xc_code = wr_q ? EXC_ADES : EXC_ADEL;
    end else if (!tlb_hit) begin
      xc_code   = wr_q ? EXC_TLBS : EXC_TLBL;
      xc_refill = 1'b1;
    end else if (!tlb_valid) begin
      xc_code = wr_q ? EXC_TLBS : EXC_TLBL;
    end else if (wr_q && !tlb_dirty) begin
      xc_code = EXC_MOD;
    end else begin
      xc_any = 1'b0;
    end
  end

  always_comb begin
    rd_shift = dc_rdata >> {paddr_q[1:0], 3'b000};
    ld_data  = rd_shift;
    if (size_q == 2'd0) begin
      ld_data = uns_q ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
    end else if (size_q == 2'd1) begin
      ld_data = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
    end
  end

  always_comb begin
    state_d        = state_q;
    vaddr_d        = vaddr_q;
    wr_d           = wr_q;
    size_d         = size_q;
    uns_d          = uns_q;
    wdata_d        = wdata_q;
    misal_d        = misal_q;
    paddr_d        = paddr_q;
    cached_d       = cached_q;
    wstrb_d        = wstrb_q;
    lane_d         = lane_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    exc_valid_d    = 1'b0;
    exc_code_d     = exc_code_q;
    exc_refill_d   = exc_refill_q;
    exc_badvaddr_d = exc_badvaddr_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          vaddr_d = req_vaddr;
          wr_d    = req_wr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          misal_d = ((req_size == 2'd1) && req_vaddr[0]) || (req_size[1] && (req_vaddr[1:0] != 2'b00));
          state_d = XLATE;
        end
      end
      XLATE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (xc_any) begin
          exc_valid_d    = 1'b1;
          exc_code_d     = xc_code;
          exc_refill_d   = xc_refill;
          exc_badvaddr_d = vaddr_q;
          state_d        = IDLE;
        end else begin
          paddr_d  = tlb_paddr;
          cached_d = tlb_cached;
          // Store lanes are placed from the physical offset and held through ISSUE.
          if (size_q == 2'd0) begin
            wstrb_d = 4'b0001 << tlb_paddr[1:0];
            lane_d  = {4{wdata_q[7:0]}};
          end else if (size_q == 2'd1) begin
            wstrb_d = 4'b0011 << tlb_paddr[1:0];
            lane_d  = {2{wdata_q[15:0]}};
          end else begin
            wstrb_d = 4'hF;
            lane_d  = wdata_q;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (dc_gnt) begin
          // A granted transaction stands even if flushed in the same cycle.
          if (wr_q) begin
            resp_valid_d = !flush;
            state_d      = IDLE;
          end else begin
            state_d = flush ? DRAIN : WAIT_R;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT_R: begin
        if (dc_rvalid) begin
          if (!flush) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_data;
          end
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dc_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      vaddr_q        <= '0;
      wr_q           <= 1'b0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      wdata_q        <= '0;
      misal_q        <= 1'b0;
      paddr_q        <= '0;
      cached_q       <= 1'b0;
      wstrb_q        <= '0;
      lane_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      exc_valid_q    <= 1'b0;
      exc_code_q     <= '0;
      exc_refill_q   <= 1'b0;
      exc_badvaddr_q <= '0;
    end else begin
      state_q        <= state_d;
      vaddr_q        <= vaddr_d;
      wr_q           <= wr_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      wdata_q        <= wdata_d;
      misal_q        <= misal_d;
      paddr_q        <= paddr_d;
      cached_q       <= cached_d;
      wstrb_q        <= wstrb_d;
      lane_q         <= lane_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      exc_valid_q    <= exc_valid_d;
      exc_code_q     <= exc_code_d;
      exc_refill_q   <= exc_refill_d;
      exc_badvaddr_q <= exc_badvaddr_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign tlb_vaddr    = (state_q == IDLE) ? req_vaddr : vaddr_q;
  assign dc_req       = (state_q == ISSUE);
  assign dc_wr        = dc_req && wr_q;
  assign dc_paddr     = {paddr_q[31:2], 2'b00};
  assign dc_wstrb     = wstrb_q;
  assign dc_wdata     = lane_q;
  assign dc_cached    = cached_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign exc_valid    = exc_valid_q;
  assign exc_code     = exc_code_q;
  assign exc_refill   = exc_refill_q;
  assign exc_badvaddr = exc_badvaddr_q;

endmodule

// File: tb/tb_dmem_xlate.sv
// Directed bench for dmem_xlate: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_dmem_xlate;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_unsigned, kernel, flush;
  logic [1:0]  req_size;
  logic [31:0] req_vaddr, req_wdata, tlb_vaddr, tlb_paddr;
  logic        tlb_hit, tlb_cached, tlb_dirty, tlb_valid, tlb_user;
  logic        dc_req, dc_wr, dc_cached, dc_gnt, dc_rvalid;
  logic [31:0] dc_paddr, dc_wdata, dc_rdata, resp_rdata, exc_badvaddr;
  logic [3:0]  dc_wstrb;
  logic        resp_valid, exc_valid, exc_refill;
  logic [4:0]  exc_code;

  int total = 0;
  int bad = 0;

  dmem_xlate dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_vaddr(req_vaddr), .req_wdata(req_wdata),
    .kernel(kernel), .flush(flush), .tlb_vaddr(tlb_vaddr),
    .tlb_paddr(tlb_paddr), .tlb_hit(tlb_hit), .tlb_cached(tlb_cached),
    .tlb_dirty(tlb_dirty), .tlb_valid(tlb_valid), .tlb_user(tlb_user),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_paddr(dc_paddr), .dc_wstrb(dc_wstrb),
    .dc_wdata(dc_wdata), .dc_cached(dc_cached), .dc_gnt(dc_gnt),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_refill(exc_refill),
    .exc_badvaddr(exc_badvaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Load extraction vectors: size, unsigned, vaddr/paddr offset, read word, expected result
  localparam logic [1:0]  LD_SZ  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  localparam logic        LD_UN  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] LD_OFF [4] = '{32'd3, 32'd3, 32'd2, 32'd2};
  localparam logic [31:0] LD_RD  [4] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_5555, 32'h8001_5555};
  localparam logic [31:0] LD_EXP [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};

  // Exception vectors: wr, size, vaddr, kernel, hit, valid, dirty, user, code, refill
  localparam logic        X_WR  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [1:0]  X_SZ  [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  localparam logic [31:0] X_VA  [5] = '{32'h0000_0002, 32'h0040_0200, 32'h0040_0204, 32'h0040_0208, 32'h0040_020C};
  localparam logic        X_KRN [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic        X_HIT [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic        X_VLD [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic        X_DRT [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic        X_USR [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [4:0]  X_CODE[5] = '{5'd4, 5'd3, 5'd1, 5'd5, 5'd2};
  localparam logic        X_REF [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic set_tlb(input logic [31:0] pa, input logic hit, input logic vld,
                         input logic drt, input logic usr, input logic cch);
    tlb_paddr = pa; tlb_hit = hit; tlb_valid = vld;
    tlb_dirty = drt; tlb_user = usr; tlb_cached = cch;
  endtask

  task automatic put_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] va, input logic [31:0] wd);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
    req_vaddr = va; req_wdata = wd;
  endtask

  // Scrambles the request fields so anything not latched would show up.
  task automatic drop_req;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd3; req_unsigned = 1'b1;
    req_vaddr = 32'hFFFF_FFF0; req_wdata = 32'h5555_AAAA;
  endtask

  task automatic test_reset;
    smp;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%h want=1", req_ready); end
    total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL rst_dc_req got=%h want=0", dc_req); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%h want=0", resp_valid); end
    total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL rst_exc_valid got=%h want=0", exc_valid); end
    total++; if (dc_paddr !== 32'h0) begin bad++; $display("FAIL rst_dc_paddr got=%h want=0", dc_paddr); end
    total++; if (dc_wstrb !== 4'h0) begin bad++; $display("FAIL rst_dc_wstrb got=%h want=0", dc_wstrb); end
    total++; if (exc_code !== 5'h0) begin bad++; $display("FAIL rst_exc_code got=%h want=0", exc_code); end
    nxt;
    rst = 1'b0;
  endtask

  task automatic test_word_load;
    set_tlb(32'h1234_5104, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    put_req(1'b0, 2'd2, 1'b0, 32'h0040_0104, 32'h0);
    smp;
    total++; if (tlb_vaddr !== 32'h0040_0104) begin bad++; $display("FAIL lw_tlb_vaddr_c0 got=%h want=00400104", tlb_vaddr); end
    nxt; drop_req;
    smp;
    total++; if (tlb_vaddr !== 32'h0040_0104) begin bad++; $display("FAIL lw_tlb_vaddr_c1 got=%h want=00400104", tlb_vaddr); end
    total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL lw_dc_req_c1 got=%h want=0", dc_req); end
    nxt; dc_gnt = 1'b1;
    smp;
    total++; if (dc_req !== 1'b1) begin bad++; $display("FAIL lw_dc_req_c2 got=%h want=1", dc_req); end
    total++; if (dc_paddr !== 32'h1234_5104) begin bad++; $display("FAIL lw_dc_paddr got=%h want=12345104", dc_paddr); end
    total++; if (dc_wr !== 1'b0) begin bad++; $display("FAIL lw_dc_wr got=%h want=0", dc_wr); end
    total++; if (dc_cached !== 1'b1) begin bad++; $display("FAIL lw_dc_cached got=%h want=1", dc_cached); end
    nxt; dc_gnt = 1'b0;
    smp;
    total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL lw_dc_req_c3 got=%h want=0", dc_req); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL lw_req_ready_c3 got=%h want=0", req_ready); end
    nxt; dc_rvalid = 1'b1; dc_rdata = 32'hDEAD_BEEF;
    smp;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lw_resp_early got=%h want=0", resp_valid); end
    nxt; dc_rvalid = 1'b0; dc_rdata = 32'h0;
    smp;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL lw_resp_valid got=%h want=1", resp_valid); end
    total++; if (resp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_resp_rdata got=%h want=deadbeef", resp_rdata); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lw_req_ready_c5 got=%h want=1", req_ready); end
    nxt;
    smp;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lw_resp_pulse got=%h want=0", resp_valid); end
    nxt;
  endtask

  task automatic test_subword_load;
    for (int i = 0; i < 4; i++) begin
      set_tlb(32'h1234_5100 + LD_OFF[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      put_req(1'b0, LD_SZ[i], LD_UN[i], 32'h0040_0100 + LD_OFF[i], 32'h0);
      nxt; drop_req;
      nxt; dc_gnt = 1'b1;
      smp;
      total++; if (dc_paddr !== 32'h1234_5100) begin bad++; $display("FAIL ld%0d_dc_paddr got=%h want=12345100", i, dc_paddr); end
      nxt; dc_gnt = 1'b0; dc_rvalid = 1'b1; dc_rdata = LD_RD[i];
      nxt; dc_rvalid = 1'b0; dc_rdata = 32'h0;
      smp;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL ld%0d_resp_valid got=%h want=1", i, resp_valid); end
      total++; if (resp_rdata !== LD_EXP[i]) begin bad++; $display("FAIL ld%0d_resp_rdata got=%h want=%h", i, resp_rdata, LD_EXP[i]); end
      nxt;
    end
  endtask

  task automatic test_store_lanes;
    logic [1:0]  sz;
    logic [31:0] va, wd, ew;
    logic [3:0]  es;
    for (int i = 0; i < 2; i++) begin
      sz = (i == 0) ? 2'd1 : 2'd0;
      va = (i == 0) ? 32'h0040_0102 : 32'h0040_0101;
      wd = (i == 0) ? 32'hABCD_1234 : 32'h0000_005A;
      es = (i == 0) ? 4'b1100 : 4'b0010;
      ew = (i == 0) ? 32'h1234_1234 : 32'h5A5A_5A5A;
      set_tlb(32'h1234_5000 | va[11:0], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      put_req(1'b1, sz, 1'b0, va, wd);
      nxt; drop_req;
      nxt; dc_gnt = 1'b1;
      smp;
      total++; if (dc_req !== 1'b1) begin bad++; $display("FAIL st%0d_dc_req got=%h want=1", i, dc_req); end
      total++; if (dc_wr !== 1'b1) begin bad++; $display("FAIL st%0d_dc_wr got=%h want=1", i, dc_wr); end
      total++; if (dc_wstrb !== es) begin bad++; $display("FAIL st%0d_dc_wstrb got=%b want=%b", i, dc_wstrb, es); end
      total++; if (dc_wdata !== ew) begin bad++; $display("FAIL st%0d_dc_wdata got=%h want=%h", i, dc_wdata, ew); end
      total++; if (dc_paddr !== 32'h1234_5100) begin bad++; $display("FAIL st%0d_dc_paddr got=%h want=12345100", i, dc_paddr); end
      nxt; dc_gnt = 1'b0;
      smp;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL st%0d_resp_valid got=%h want=1", i, resp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL st%0d_req_ready got=%h want=1", i, req_ready); end
      nxt;
    end
  endtask

  task automatic test_exceptions;
    for (int i = 0; i < 5; i++) begin
      kernel = X_KRN[i];
      set_tlb(32'h1234_5000 | X_VA[i][11:0], X_HIT[i], X_VLD[i], X_DRT[i], X_USR[i], 1'b1);
      put_req(X_WR[i], X_SZ[i], 1'b0, X_VA[i], 32'h1111_2222);
      nxt; drop_req;
      nxt;
      smp;
      total++; if (exc_valid !== 1'b1) begin bad++; $display("FAIL exc%0d_valid got=%h want=1", i, exc_valid); end
      total++; if (exc_code !== X_CODE[i]) begin bad++; $display("FAIL exc%0d_code got=%0d want=%0d", i, exc_code, X_CODE[i]); end
      total++; if (exc_refill !== X_REF[i]) begin bad++; $display("FAIL exc%0d_refill got=%h want=%h", i, exc_refill, X_REF[i]); end
      total++; if (exc_badvaddr !== X_VA[i]) begin bad++; $display("FAIL exc%0d_badvaddr got=%h want=%h", i, exc_badvaddr, X_VA[i]); end
      total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL exc%0d_dc_req got=%h want=0", i, dc_req); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL exc%0d_resp got=%h want=0", i, resp_valid); end
      nxt;
      smp;
      total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL exc%0d_pulse got=%h want=0", i, exc_valid); end
      total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL exc%0d_dc_req_after got=%h want=0", i, dc_req); end
      nxt;
    end
    kernel = 1'b1;
  endtask

  task automatic test_flush;
    // flush while idle blocks acceptance
    set_tlb(32'h1234_5400, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    put_req(1'b0, 2'd2, 1'b0, 32'h0040_0400, 32'h0);
    flush = 1'b1;
    nxt; drop_req; flush = 1'b0;
    smp;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL fl_idle_req_ready got=%h want=1", req_ready); end
    nxt;
    smp;
    total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL fl_idle_dc_req got=%h want=0", dc_req); end
    nxt;
    // flush in XLATE suppresses even a pending address error
    put_req(1'b0, 2'd2, 1'b0, 32'h0040_0402, 32'h0);
    nxt; drop_req; flush = 1'b1;
    nxt; flush = 1'b0;
    smp;
    total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL fl_xl_exc got=%h want=0", exc_valid); end
    total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL fl_xl_dc_req got=%h want=0", dc_req); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL fl_xl_req_ready got=%h want=1", req_ready); end
    nxt;
    // flush in WAIT_R: the late read data is swallowed
    put_req(1'b0, 2'd2, 1'b0, 32'h0040_0400, 32'h0);
    nxt; drop_req;
    nxt; dc_gnt = 1'b1;
    nxt; dc_gnt = 1'b0; flush = 1'b1;
    nxt; flush = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'h0BAD_0BAD;
    smp;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL fl_wr_drain_ready got=%h want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL fl_wr_resp_c4 got=%h want=0", resp_valid); end
    nxt; dc_rvalid = 1'b0; dc_rdata = 32'h0;
    smp;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL fl_wr_resp_c5 got=%h want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL fl_wr_req_ready got=%h want=1", req_ready); end
    nxt;
  endtask

  task automatic test_back_to_back;
    set_tlb(32'h1234_5200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    put_req(1'b1, 2'd2, 1'b0, 32'h0040_0200, 32'hCAFE_F00D);
    nxt; drop_req;
    nxt;
    for (int k = 0; k < 4; k++) begin
      dc_gnt = (k == 3);
      smp;
      total++; if (dc_req !== 1'b1) begin bad++; $display("FAIL b2b_st_req%0d got=%h want=1", k, dc_req); end
      total++; if (dc_paddr !== 32'h1234_5200) begin bad++; $display("FAIL b2b_st_paddr%0d got=%h want=12345200", k, dc_paddr); end
      total++; if (dc_wstrb !== 4'hF) begin bad++; $display("FAIL b2b_st_wstrb%0d got=%h want=f", k, dc_wstrb); end
      total++; if (dc_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_st_wdata%0d got=%h want=cafef00d", k, dc_wdata); end
      total++; if (dc_wr !== 1'b1) begin bad++; $display("FAIL b2b_st_wr%0d got=%h want=1", k, dc_wr); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_st_early%0d got=%h want=0", k, resp_valid); end
      nxt;
    end
    dc_gnt = 1'b0;
    set_tlb(32'h1234_5300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    put_req(1'b0, 2'd2, 1'b0, 32'h0040_0300, 32'h0);
    smp;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_st_resp got=%h want=1", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%h want=1", req_ready); end
    nxt; drop_req;
    nxt;
    for (int k = 0; k < 4; k++) begin
      dc_gnt = (k == 3);
      smp;
      total++; if (dc_req !== 1'b1) begin bad++; $display("FAIL b2b_ld_req%0d got=%h want=1", k, dc_req); end
      total++; if (dc_paddr !== 32'h1234_5300) begin bad++; $display("FAIL b2b_ld_paddr%0d got=%h want=12345300", k, dc_paddr); end
      total++; if (dc_wr !== 1'b0) begin bad++; $display("FAIL b2b_ld_wr%0d got=%h want=0", k, dc_wr); end
      nxt;
    end
    dc_gnt = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'h1122_3344;
    smp;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_ld_early got=%h want=0", resp_valid); end
    nxt; dc_rvalid = 1'b0; dc_rdata = 32'h0;
    smp;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_ld_resp got=%h want=1", resp_valid); end
    total++; if (resp_rdata !== 32'h1122_3344) begin bad++; $display("FAIL b2b_ld_rdata got=%h want=11223344", resp_rdata); end
    nxt;
  endtask

  task automatic test_reset_mid;
    set_tlb(32'h1234_5500, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    put_req(1'b0, 2'd2, 1'b0, 32'h0040_0500, 32'h0);
    nxt; drop_req;
    nxt;
    smp;
    total++; if (dc_req !== 1'b1) begin bad++; $display("FAIL rmid_dc_req_before got=%h want=1", dc_req); end
    nxt; rst = 1'b1;
    nxt; rst = 1'b0;
    smp;
    total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL rmid_dc_req got=%h want=0", dc_req); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_req_ready got=%h want=1", req_ready); end
    nxt;
  endtask

  initial begin
    rst = 1'b1; kernel = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_vaddr = 32'h0; req_wdata = 32'h0;
    set_tlb(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dc_gnt = 1'b0; dc_rvalid = 1'b0; dc_rdata = 32'h0;
    nxt;
    nxt;
    test_reset;
    test_word_load;
    test_subword_load;
    test_store_lanes;
    test_exceptions;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
